// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word geometry
// and a helper that derives the word-index width from the storage depth.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    // Number of word-index bits needed to address a storage array of depth words.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IW = idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [31:0]   d_i,
    output logic [31:0]   q_o
);

    logic [31:0] mem [DEPTH_WORDS];

    // Store port: one word written per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx_i] <= d_i;
        end
    end

    assign q_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time and
// completes it WAIT_CYC+1 cycles after acceptance with a one-cycle ack pulse.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned accesses complete with err=1,
// no store and no rdata update; when undefined addr[1:0] is ignored and err stays 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYC    = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int IW = idx_width(DEPTH_WORDS);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          we_reg;
    logic [IW-1:0] idx_reg;
    logic [31:0]   wdata_reg;
    logic          mis_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;

    logic          accept;
    logic          enter_resp;
    logic          mis_now;
    logic          unused_addr;

    logic          txn_we;
    logic [IW-1:0] txn_idx;
    logic [31:0]   txn_wdata;
    logic          txn_mis;
    logic          arr_we;
    logic [31:0]   arr_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_now     = |addr[WORD_SHIFT-1:0];
    assign unused_addr = ^addr[31:IW+WORD_SHIFT];
`else
    assign mis_now     = 1'b0;
    assign unused_addr = ^{addr[31:IW+WORD_SHIFT], addr[WORD_SHIFT-1:0]};
`endif

    // With WAIT_CYC=0 the transaction completes on the accepting edge, before the
    // latches hold it, so the live request is used while still in IDLE.
    assign txn_we    = (state_reg == IDLE) ? we : we_reg;
    assign txn_idx   = (state_reg == IDLE) ? addr[IW+WORD_SHIFT-1:WORD_SHIFT] : idx_reg;
    assign txn_wdata = (state_reg == IDLE) ? wdata : wdata_reg;
    assign txn_mis   = (state_reg == IDLE) ? mis_now : mis_reg;

    // A reset on the committing edge must also suppress the store.
    assign arr_we = enter_resp & txn_we & ~txn_mis & clr;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we_i (arr_we),
        .idx_i(txn_idx),
        .d_i  (txn_wdata),
        .q_o  (arr_q)
    );

    // Next-state and wait-counter logic for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYC - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, request latches, load data and error flag; clr=0 aborts any transaction.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= 32'h0;
            mis_reg   <= 1'b0;
            rdata_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= we;
                idx_reg   <= addr[IW+WORD_SHIFT-1:WORD_SHIFT];
                wdata_reg <= wdata;
                mis_reg   <= mis_now;
            end
            err_reg <= enter_resp & txn_mis;
            if (enter_resp & ~txn_we & ~txn_mis) begin
                rdata_reg <= arr_q;
            end
        end
    end

    assign rdata = rdata_reg;
    assign ack   = (state_reg == RESP);
    assign busy  = (state_reg != IDLE);
    assign err   = err_reg & ack;

endmodule
